// File: rtl/fetch_pkg.sv
// fetch_pkg: encodings and constants shared by the fetch stage and the decoder.
// Revision 1.0
`default_nettype none

package fetch_pkg;

  localparam logic [1:0] BR_BZ  = 2'd0;
  localparam logic [1:0] BR_BNZ = 2'd1;
  localparam logic [1:0] BR_JMP = 2'd2;
  localparam logic [1:0] BR_JMR = 2'd3;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    IDLE  = 2'd2,
    DROP  = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_branch_unit.sv
// fetch_branch_unit: decides whether a consumed branch is taken and computes its target.
// Revision 1.0
`default_nettype none

module fetch_branch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W = 16
) (
  input  logic [1:0]      br_type,
  input  logic            zero,
  input  logic [PC_W-1:0] pc_of_op,
  input  logic [15:0]     br_offset,
  input  logic [PC_W-1:0] br_reg,
  output logic            taken,
  output logic [PC_W-1:0] target
);

  localparam int unsigned EXT_W = (PC_W > 16) ? PC_W : 16;

  logic [EXT_W-1:0] off_ext;

  // Sign-extend the offset, add at the wider width, then truncate to PC_W.
  assign off_ext = EXT_W'($signed(br_offset));

  always_comb begin
    taken  = 1'b0;
    target = PC_W'(EXT_W'(pc_of_op) + off_ext);
    case (br_type)
      BR_BZ:   taken = zero;
      BR_BNZ:  taken = ~zero;
      BR_JMP:  taken = 1'b1;
      BR_JMR: begin
        taken  = 1'b1;
        target = br_reg;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, req/ack instruction fetch, two-entry buffer and redirect/flush.
// Revision 1.0
`default_nettype none

module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [31:0]     op,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [PC_W-1:0] pc_of_op,
  input  logic            br_valid,
  input  logic [1:0]      br_type,
  input  logic [15:0]     br_offset,
  input  logic [PC_W-1:0] br_reg,
  input  logic            zero
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] drop_addr_q, drop_addr_d;
  logic            head_vld_q, head_vld_d;
  logic [31:0]     head_q, head_d;
  logic [PC_W-1:0] head_pc_q, head_pc_d;
  logic            pf_vld_q, pf_vld_d;
  logic [31:0]     pf_q, pf_d;
  logic [PC_W-1:0] pf_pc_q, pf_pc_d;

  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            consume;
  logic            redirect;
  logic            ack_take;

  fetch_branch_unit #(
    .PC_W(PC_W)
  ) u_branch (
    .br_type  (br_type),
    .zero     (zero),
    .pc_of_op (head_pc_q),
    .br_offset(br_offset),
    .br_reg   (br_reg),
    .taken    (br_taken),
    .target   (br_target)
  );

  assign consume  = head_vld_q & op_ready;
  assign redirect = consume & br_valid & br_taken;
  assign ack_take = (state_q == REQ) & imem_ack & ~redirect;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    head_vld_d  = head_vld_q;
    head_d      = head_q;
    head_pc_d   = head_pc_q;
    pf_vld_d    = pf_vld_q;
    pf_d        = pf_q;
    pf_pc_d     = pf_pc_q;

    if (consume) begin
      head_vld_d = pf_vld_q;
      head_d     = pf_q;
      head_pc_d  = pf_pc_q;
      pf_vld_d   = 1'b0;
    end

    // Arriving word goes to the head if it is free after this cycle's shift.
    if (ack_take) begin
      fetch_pc_d = fetch_pc_q + PC_W'(1);
      if (!head_vld_d) begin
        head_vld_d = 1'b1;
        head_d     = imem_data;
        head_pc_d  = fetch_pc_q;
      end else begin
        pf_vld_d = 1'b1;
        pf_d     = imem_data;
        pf_pc_d  = fetch_pc_q;
      end
    end

    case (state_q)
      START: state_d = REQ;
      REQ: begin
        if (imem_ack && head_vld_d && pf_vld_d) state_d = IDLE;
      end
      IDLE: begin
        if (!(head_vld_d && pf_vld_d)) state_d = REQ;
      end
      DROP: begin
        if (imem_ack) state_d = REQ;
      end
      default: state_d = START;
    endcase

    // An unanswered request must still complete on its old address before refetching.
    if (redirect) begin
      head_vld_d = 1'b0;
      pf_vld_d   = 1'b0;
      fetch_pc_d = br_target;
      if ((state_q == REQ) && !imem_ack) begin
        state_d     = DROP;
        drop_addr_d = fetch_pc_q;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= START;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      head_vld_q  <= 1'b0;
      head_q      <= NOP;
      head_pc_q   <= '0;
      pf_vld_q    <= 1'b0;
      pf_q        <= NOP;
      pf_pc_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      head_vld_q  <= head_vld_d;
      head_q      <= head_d;
      head_pc_q   <= head_pc_d;
      pf_vld_q    <= pf_vld_d;
      pf_q        <= pf_d;
      pf_pc_q     <= pf_pc_d;
    end
  end

  assign imem_req  = (state_q == REQ) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
  assign op        = head_vld_q ? head_q : NOP;
  assign op_valid  = head_vld_q;
  assign pc_of_op  = head_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch (16-bit and 4-bit PC instances).
// Revision 1.0
`default_nettype none

module tb_instruction_fetch;

  function automatic logic [31:0] mw(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] op;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] pc_of_op;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [15:0] br_offset;
  logic [15:0] br_reg;
  logic        zero;

  logic [3:0]  q_addr;
  logic        q_req;
  logic [31:0] q_op;
  logic        q_op_valid;
  logic [3:0]  q_pc;

  int          mem_lat;
  logic        force_ack;
  logic [7:0]  wait_cnt;
  logic [15:0] br_pc;
  int          br_armed = 0;
  int          br_seen  = 0;
  int          n_chk    = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .op(op), .op_valid(op_valid),
    .op_ready(op_ready), .pc_of_op(pc_of_op), .br_valid(br_valid), .br_type(br_type),
    .br_offset(br_offset), .br_reg(br_reg), .zero(zero)
  );

  instruction_fetch #(.PC_W(4), .RESET_PC(4'd14)) dut4 (
    .clk(clk), .rst_n(rst_n), .imem_addr(q_addr), .imem_req(q_req),
    .imem_ack(q_req), .imem_data({28'h0, q_addr}), .op(q_op), .op_valid(q_op_valid),
    .op_ready(1'b1), .pc_of_op(q_pc), .br_valid(1'b0), .br_type(2'd0),
    .br_offset(16'h0), .br_reg(4'h0), .zero(1'b0)
  );

  // Memory: acks after mem_lat waiting cycles (0 = same cycle as request).
  always_comb imem_ack  = force_ack | (imem_req & (int'(wait_cnt) >= mem_lat));
  always_comb imem_data = mw(imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= 8'd0;
    else if (!imem_req || imem_ack) wait_cnt <= 8'd0;
    else wait_cnt <= wait_cnt + 8'd1;
  end

  // Decoder model: one armed branch at br_pc, retired when consumed.
  always_comb br_valid = op_valid && (br_seen < br_armed) && (pc_of_op == br_pc);

  always @(posedge clk) begin
    if (br_valid && op_valid && op_ready) br_seen <= br_seen + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Monitor: every consumed op is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL op_unexpected: got pc %h expected none", pc_of_op);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("op_word", op, mw(e));
          chk("op_pc", {16'h0, pc_of_op}, {16'h0, e});
        end
      end else if (!op_valid) begin
        chk("op_nop", op, 32'h0);
      end
    end
  end

  task automatic arm(input logic [1:0] t, input logic [15:0] pc, input logic [15:0] off,
                     input logic [15:0] rg, input logic z);
    br_type   = t;
    br_pc     = pc;
    br_offset = off;
    br_reg    = rg;
    zero      = z;
    br_armed++;
  endtask

  task automatic wait_fire(input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (br_seen != br_armed && k < 60);
    chk({nm, "_fired"}, br_seen, br_armed);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq[$];
    logic [3:0]  a4;
    rst_n = 1'b0; op_ready = 1'b1; mem_lat = 0; force_ack = 1'b0;
    br_type = 2'd0; br_pc = 16'hFFFF; br_offset = 16'h0; br_reg = 16'h0; zero = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", {16'h0, imem_addr}, 32'h0);
    chk("rst_op", op, 32'h0);
    chk("rst_op_valid", {31'h0, op_valid}, 32'h0);
    chk("rst_pc_of_op", {16'h0, pc_of_op}, 32'h0);

    seq = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9, 16'd10,
            16'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd4, 16'd7};
    foreach (seq[i]) exp_q.push_back(seq[i]);
    rst_n = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_addr", {16'h0, imem_addr}, i);
      chk("stream_req", {31'h0, imem_req}, 32'h1);
      a4 = 4'(14 + i);
      chk("pc4_addr", {28'h0, q_addr}, {28'h0, a4});
      if (i == 0) begin
        chk("first_op_valid", {31'h0, op_valid}, 32'h0);
      end else begin
        a4 = 4'(13 + i);
        chk("pc4_op", q_op, {28'h0, a4});
        chk("pc4_op_valid", {31'h0, q_op_valid}, 32'h1);
      end
    end

    // Stall five cycles: two words buffered, request stops.
    @(posedge clk); #1;
    op_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("stall_req", {31'h0, imem_req}, 32'h0);
    chk("stall_head", op, mw(16'd3));
    repeat (2) @(posedge clk); #1;
    op_ready = 1'b1;
    @(negedge clk);
    chk("unstall_idle_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    chk("unstall_req", {31'h0, imem_req}, 32'h1);
    chk("unstall_addr", {16'h0, imem_addr}, 32'd5);

    arm(2'd2, 16'd10, 16'hFFFC, 16'h0, 1'b0);
    wait_fire("jmp");
    chk("jmp_addr", {16'h0, imem_addr}, 32'd6);
    chk("jmp_op_valid", {31'h0, op_valid}, 32'h0);

    arm(2'd0, 16'd8, 16'd3, 16'h0, 1'b0);
    wait_fire("bz_nt");
    chk("bz_nt_op_valid", {31'h0, op_valid}, 32'h1);
    chk("bz_nt_pc", {16'h0, pc_of_op}, 32'd9);

    arm(2'd2, 16'd11, 16'hFFF9, 16'h0, 1'b0);
    wait_fire("jmp_back");
    chk("jmp_back_addr", {16'h0, imem_addr}, 32'd4);

    arm(2'd0, 16'd4, 16'd3, 16'h0, 1'b1);
    wait_fire("bz_t");
    chk("bz_t_addr", {16'h0, imem_addr}, 32'd7);
    chk("bz_t_op_valid", {31'h0, op_valid}, 32'h0);

    // JMR while a 3-cycle fetch of word 8 is outstanding.
    mem_lat = 3;
    arm(2'd3, 16'd7, 16'h0, 16'h0040, 1'b0);
    wait_fire("jmr");
    for (int k = 0; k < 3; k++) begin
      chk("drop_addr", {16'h0, imem_addr}, 32'd8);
      chk("drop_req", {31'h0, imem_req}, 32'h1);
      chk("drop_op_valid", {31'h0, op_valid}, 32'h0);
      @(negedge clk);
    end
    chk("jmr_addr", {16'h0, imem_addr}, 32'h40);
    chk("jmr_req", {31'h0, imem_req}, 32'h1);
    chk("jmr_op_valid", {31'h0, op_valid}, 32'h0);

    // Reset mid-request, with acks forced while reset is held.
    @(posedge clk); #1;
    rst_n = 1'b0; force_ack = 1'b1; mem_lat = 0;
    #1;
    chk("rst2_req", {31'h0, imem_req}, 32'h0);
    chk("rst2_op", op, 32'h0);
    chk("rst2_op_valid", {31'h0, op_valid}, 32'h0);
    chk("rst2_addr", {16'h0, imem_addr}, 32'h0);
    chk("rst2_pc_of_op", {16'h0, pc_of_op}, 32'h0);
    repeat (2) @(posedge clk); #1;
    exp_q.push_back(16'd0); exp_q.push_back(16'd1); exp_q.push_back(16'd2);
    rst_n = 1'b1; force_ack = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("restart_addr", {16'h0, imem_addr}, i);
      if (i == 0) chk("restart_op_valid", {31'h0, op_valid}, 32'h0);
    end
    @(posedge clk); #1;
    op_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the instruction decoder. Keeps the program counter and fetches 32-bit words from instruction memory over a req/ack handshake. Buffers up to two fetched words and presents them to the combinational decoder as `op`. Resolves BZ/BNZ/JMP/JMR redirects reported back from decode/execute, flushing wrong-path words, including a fetch still in flight.

## Interface
Parameters:
- `PC_W`, 16, width of the word-addressed PC and of `imem_addr`.
- `RESET_PC`, 0, first fetch address after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  PC_W  fetch address; stable while `imem_req`=1 and no `imem_ack`.
- `imem_req`  out  1  fetch request.
- `imem_ack`  in  1  `imem_data` valid this cycle; may assert in the same cycle as `imem_req`.
- `imem_data`  in  32  fetched instruction word.
- `op`  out  32  instruction to decoder; forced to 32'h0 (NOP) whenever `op_valid`=0.
- `op_valid`  out  1  `op` holds a real instruction.
- `op_ready`  in  1  downstream consumes `op` this cycle.
- `pc_of_op`  out  PC_W  address of the word in `op`.
- `br_valid`  in  1  the consumed `op` is a branch/jump; sampled only when `op_valid & op_ready`.
- `br_type`  in  2  00 BZ, 01 BNZ, 10 JMP, 11 JMR.
- `br_offset`  in  16  signed immediate offset.
- `br_reg`  in  PC_W  register value for JMR.
- `zero`  in  1  ALU zero flag.

## Operation
- Two-entry buffer: head (`op`, `pc_of_op`) plus a prefetch slot (`pf`, `pf_pc`). An ack fills the head if it is empty or being consumed this cycle; otherwise it fills `pf`. On consume, `pf` shifts into the head.
- Request control FSM:
  - START: reset state; `imem_req`=0; goes to REQ after one cycle.
  - REQ: `imem_req`=1, `imem_addr`=`fetch_pc`.
    - On ack with no redirect: store the word, `fetch_pc`+1, wrap mod 2^PC_W.
    - Stays in REQ unless both slots will be full, then goes to IDLE.
  - IDLE: `imem_req`=0; returns to REQ once a slot frees.
  - DROP: `imem_req`=1 on the stale address. The next ack is discarded; then goes to REQ at `fetch_pc`.
- Branch taken:
  - BZ when `zero`=1; BNZ when `zero`=0; JMP and JMR always.
- Target, truncated to PC_W:
  - BZ/BNZ/JMP: `pc_of_op` + sign-extended `br_offset`.
  - JMR: `br_reg`.
- Taken redirect, in the consume cycle:
  - Clears head and `pf`; `fetch_pc` ← target.
  - Request outstanding without ack → DROP.
  - Ack in the same cycle → data discarded; next state REQ.
  - Not-taken branch behaves as an ordinary consume.
- `br_valid` without `op_valid & op_ready` is ignored.

## Timing
- Reset values: `imem_req` 0, `imem_addr` RESET_PC, `op` 0, `op_valid` 0, `pc_of_op` 0; internally `fetch_pc` RESET_PC, both slots empty, state START.
- First `imem_req` in the 1st cycle after `rst_n` deasserts.
- Ack at edge N → `op_valid` from edge N. No combinational path from `imem_data` to `op`.
- Zero-wait memory (ack tied high) with `op_ready`=1 sustains one instruction per cycle.
- Taken redirect at edge N: `op_valid`=0 in cycle N.
  - `imem_addr`=target in cycle N if no drop is needed.
  - Otherwise `imem_addr`=target in the cycle after the discarded ack.
- `rst_n` low mid-fetch: immediate return to reset values. An ack arriving during reset is ignored.

## Structure
- Shared package `fetch_pkg`:
  - `br_type` encodings BR_BZ=0, BR_BNZ=1, BR_JMP=2, BR_JMR=3 (identical to the decoder's encoding).
  - FSM state enum START/REQ/IDLE/DROP.
  - NOP constant 32'h0.
- Sub-module `fetch_branch_unit`: combinational. Takes `br_type`, `zero`, `pc_of_op`, `br_offset`, `br_reg`; produces `taken` and `target`. Instantiated once.

## Test plan
- Reset release, ack tied high, `op_ready`=1 → `imem_addr` 0,1,2,3 on consecutive cycles. `op` shows words 0,1,2 with `pc_of_op` 0,1,2 from the 2nd cycle.
- `op_ready`=0 for 5 cycles → exactly two words buffered, `imem_req` drops to 0. On release: words delivered in order with no loss.
- JMP with `br_offset`=16'hFFFC at `pc_of_op`=10 → next `imem_addr`=6. The prefetched word 11 is never presented.
- BZ with `zero`=0 → not taken; next `op` is `pc_of_op`+1. Same instruction with `zero`=1 and `br_offset`=3 from pc 4 → `imem_addr`=7.
- JMR `br_reg`=16'h0040 while a 3-cycle-latency fetch is outstanding → DROP. Stale ack is discarded and `op_valid` stays 0. Then `imem_addr`=0x40.
- PC_W=4, `fetch_pc`=15 → next fetch address 0. `rst_n` pulsed low mid-request → `imem_req`=0 and `op`=0 immediately; restart at RESET_PC.
